// File: rtl/vol_scaler.sv
// Volume scaler: a 2-stage valid/ready pipeline that multiplies each sample by gain/4, saturates it and counts clips.
// Gain ramping is optional: define VOL_SCALER_RAMP_EN to step cur_gain toward scale once every RAMP_LEN accepted samples.
module vol_scaler #(
  parameter int DW       = 16,
  parameter int RAMP_LEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           scale,
  input  logic signed [DW-1:0] in_smpl,
  input  logic                 in_vld,
  output logic                 in_rdy,
  output logic signed [DW-1:0] out_smpl,
  output logic                 out_vld,
  input  logic                 out_rdy,
  input  logic                 clip_clr,
  output logic [7:0]           clip_cnt,
  output logic                 ramp_busy
);

  localparam int PW = DW + 3;
  localparam logic signed [DW-1:0] SMPL_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMPL_MIN = {1'b1, {(DW-1){1'b0}}};

  if (RAMP_LEN < 2 || RAMP_LEN > 1024 || (RAMP_LEN & (RAMP_LEN - 1)) != 0) begin : g_bad_ramp_len
    $error("vol_scaler: RAMP_LEN must be a power of two in 2..1024");
  end

  logic [2:0]           cur_gain;
  logic                 s1_vld;
  logic                 s2_vld;
  logic                 s1_adv;
  logic                 s2_adv;
  logic                 accept;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] s1_prod;
  logic signed [PW-1:0] shifted;
  logic signed [DW-1:0] s2_smpl;
  logic signed [DW-1:0] sat_smpl;
  logic                 sat_hit;

  // S2 frees up when empty or draining; S1 may then move into it, which also frees S1 for a new sample.
  assign s2_adv = !s2_vld || out_rdy;
  assign s1_adv = !s1_vld || s2_adv;
  assign in_rdy = !rst && s1_adv;
  assign accept = in_vld && in_rdy;

  // The gain code is unsigned 0..7, so widen it with a zero sign bit before the signed multiply.
  assign prod    = PW'(in_smpl) * PW'($signed({1'b0, cur_gain}));
  assign shifted = s1_prod >>> 2;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    sat_hit  = 1'b0;
    sat_smpl = shifted[DW-1:0];
    // The result fits in DW bits only when all bits above the DW-bit sign position agree with it.
    if (!(&shifted[PW-1:DW-1]) && (|shifted[PW-1:DW-1])) begin
      sat_hit  = 1'b1;
      sat_smpl = shifted[PW-1] ? SMPL_MIN : SMPL_MAX;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      s2_smpl  <= '0;
      clip_cnt <= '0;
    end else begin
      if (s1_adv) begin
        s1_vld <= accept;
      end
      if (s2_adv) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_smpl <= sat_smpl;
        end
      end
      if (clip_clr) begin
        clip_cnt <= '0;
      end else if (s2_adv && s1_vld && sat_hit && clip_cnt != 8'hFF) begin
        clip_cnt <= clip_cnt + 8'd1;
      end
    end
  end

  // NOTE: the product register is datapath only and is left unreset; s1_vld qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_prod <= prod;
    end
  end

  assign out_smpl = s2_smpl;
  assign out_vld  = s2_vld;

`ifdef VOL_SCALER_RAMP_EN
  localparam int CW = $clog2(RAMP_LEN);

  logic [2:0]    gain_q;
  logic [CW-1:0] ramp_cnt;

  // Only accepted samples pace the ramp, so an idle input freezes the gain; a new scale redirects it mid-count.
  always_ff @(posedge clk) begin
    if (rst) begin
      gain_q   <= 3'd5;
      ramp_cnt <= '0;
    end else if (gain_q == scale) begin
      ramp_cnt <= '0;
    end else if (accept) begin
      if (ramp_cnt == CW'(RAMP_LEN - 1)) begin
        ramp_cnt <= '0;
        gain_q   <= (scale > gain_q) ? gain_q + 3'd1 : gain_q - 3'd1;
      end else begin
        ramp_cnt <= ramp_cnt + CW'(1);
      end
    end
  end

  assign cur_gain  = gain_q;
  assign ramp_busy = (gain_q != scale);
`else
  assign cur_gain  = scale;
  assign ramp_busy = 1'b0;
`endif

endmodule

// File: tb/tb_vol_scaler.sv
// Self-checking bench for vol_scaler: randomized traffic scored against a queue-based gain/4 saturating model.
module tb_vol_scaler;

  localparam int DW   = 16;
  localparam int RL   = 64;
  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [2:0]           scale;
  logic signed [DW-1:0] in_smpl;
  logic                 in_vld;
  logic                 in_rdy;
  logic signed [DW-1:0] out_smpl;
  logic                 out_vld;
  logic                 out_rdy;
  logic                 clip_clr;
  logic [7:0]           clip_cnt;
  logic                 ramp_busy;

  always #5 clk = ~clk;

  vol_scaler #(.DW(DW), .RAMP_LEN(RL)) dut (
    .clk(clk), .rst(rst), .scale(scale), .in_smpl(in_smpl), .in_vld(in_vld),
    .in_rdy(in_rdy), .out_smpl(out_smpl), .out_vld(out_vld), .out_rdy(out_rdy),
    .clip_clr(clip_clr), .clip_cnt(clip_cnt), .ramp_busy(ramp_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_acc    = 0;

  // Reference state: expected outputs in acceptance order, observed outputs in retire order.
  int exp_q[$];
  int exp_cyc[$];
  int got_q[$];
  int got_cyc[$];
  int m_gain = 5;
  int m_cnt  = 0;
  int m_clip = 0;

  logic                 obs_in_rdy;
  logic                 obs_out_vld;
  logic                 obs_busy;
  logic signed [DW-1:0] obs_out;
  logic [7:0]           obs_clip;
  bit                   busy_seen;

  function automatic int ref_out(int x, int g);
    int p, q;
    p = x * g;
    q = p / 4;
    if (p < 0 && (p % 4) != 0) q = q - 1;
    if (q > MAXV) q = MAXV;
    if (q < MINV) q = MINV;
    return q;
  endfunction

  function automatic bit ref_clips(int x, int g);
    int p, q;
    p = x * g;
    q = p / 4;
    if (p < 0 && (p % 4) != 0) q = q - 1;
    return (q > MAXV) || (q < MINV);
  endfunction

  function automatic int got_at(int i);
    if (i < got_q.size()) return got_q[i];
    return -999999;
  endfunction

  // One clock: observe at the falling edge, update the model for what the rising edge will do.
  task automatic step();
    bit acc, ret;
    int g;
    @(negedge clk);
    obs_in_rdy  = in_rdy;
    obs_out_vld = out_vld;
    obs_out     = out_smpl;
    obs_clip    = clip_cnt;
    obs_busy    = ramp_busy;
    if (ramp_busy !== 1'b0) busy_seen = 1'b1;
    acc = (in_vld === 1'b1) && (in_rdy === 1'b1);
    ret = (out_vld === 1'b1) && (out_rdy === 1'b1);
`ifdef VOL_SCALER_RAMP_EN
    g = m_gain;
`else
    g = int'(scale);
`endif
    if (rst === 1'b1) begin
      exp_q.delete();
      exp_cyc.delete();
      m_gain = 5;
      m_cnt  = 0;
      m_clip = 0;
    end else begin
      if (ret) begin
        got_q.push_back(int'(obs_out));
        got_cyc.push_back(cyc);
      end
      if (acc) begin
        exp_q.push_back(ref_out(int'(in_smpl), g));
        exp_cyc.push_back(cyc);
        n_acc++;
        if (ref_clips(int'(in_smpl), g) && m_clip < 255) m_clip++;
      end
      if (clip_clr === 1'b1) m_clip = 0;
      if (m_gain == int'(scale)) begin
        m_cnt = 0;
      end else if (acc) begin
        m_cnt++;
        if (m_cnt == RL) begin
          m_cnt  = 0;
          m_gain = (int'(scale) > m_gain) ? m_gain + 1 : m_gain - 1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    in_vld = 1'b0;
    for (int i = 0; i < 50 && got_q.size() < exp_q.size(); i++) step();
  endtask

  task automatic clear_q();
    exp_q.delete();
    exp_cyc.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b1; in_smpl = DW'($urandom); scale = 3'd5;
    out_rdy = 1'b1; clip_clr = 1'b0;
    step();
    step();
    n_checks++;
    if (obs_in_rdy !== 1'b0) $display("FAIL reset_in_rdy: got %b expected 0", obs_in_rdy);
    else n_pass++;
    rst = 1'b0; in_vld = 1'b0;
    step();
    n_checks++;
    if (obs_out_vld !== 1'b0) $display("FAIL reset_out_vld: got %b expected 0", obs_out_vld);
    else n_pass++;
    n_checks++;
    if (obs_out !== 16'sd0) $display("FAIL reset_out_smpl: got %0d expected 0", obs_out);
    else n_pass++;
    n_checks++;
    if (obs_clip !== 8'd0) $display("FAIL reset_clip_cnt: got %0d expected 0", obs_clip);
    else n_pass++;
    n_checks++;
    if (obs_busy !== 1'b0) $display("FAIL reset_ramp_busy: got %b expected 0", obs_busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic rdy_a, rdy_b;
    clear_q();
    scale = 3'd5; out_rdy = 1'b1; in_vld = 1'b1;
    in_smpl = 16'sd1000;
    step();
    rdy_a = obs_in_rdy;
    in_smpl = -16'sd1000;
    step();
    rdy_b = obs_in_rdy;
    drain();
    n_checks++;
    if ((rdy_a & rdy_b) !== 1'b1) $display("FAIL basic_in_rdy: got %b%b expected 11", rdy_a, rdy_b);
    else n_pass++;
    n_checks++;
    if (got_at(0) !== 1250) $display("FAIL basic_out0: got %0d expected 1250", got_at(0));
    else n_pass++;
    n_checks++;
    if (got_at(1) !== -1250) $display("FAIL basic_out1: got %0d expected -1250", got_at(1));
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got_cyc.size() <= i || got_cyc[i] - exp_cyc[i] !== 2)
        $display("FAIL basic_latency[%0d]: got %0d expected 2", i,
                 (got_cyc.size() > i) ? got_cyc[i] - exp_cyc[i] : -1);
      else n_pass++;
    end
  endtask

  task automatic test_clip();
    scale = 3'd7; out_rdy = 1'b1; in_vld = 1'b0;
    clip_clr = 1'b1;
    step();
    clip_clr = 1'b0;
    clear_q();
    in_vld = 1'b1; in_smpl = 16'sd32767;
    step();
    drain();
    step();
    n_checks++;
    if (got_at(0) !== MAXV || obs_clip !== 8'd1)
      $display("FAIL clip_pos: got out=%0d cnt=%0d expected out=32767 cnt=1", got_at(0), obs_clip);
    else n_pass++;
    in_vld = 1'b1; in_smpl = -16'sd32768;
    step();
    drain();
    step();
    n_checks++;
    if (got_at(1) !== MINV || obs_clip !== 8'd2)
      $display("FAIL clip_neg: got out=%0d cnt=%0d expected out=-32768 cnt=2", got_at(1), obs_clip);
    else n_pass++;
    in_vld = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_smpl = (i % 2 == 0) ? 16'sd32000 : -16'sd32000;
      step();
    end
    drain();
    step();
    n_checks++;
    if (obs_clip !== 8'd255 || m_clip !== 255)
      $display("FAIL clip_saturate: got %0d expected 255", obs_clip);
    else n_pass++;
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL clip_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_at(i) !== exp_q[i]) begin
        n_checks++;
        $display("FAIL clip_stream[%0d]: got %0d expected %0d", i, got_at(i), exp_q[i]);
      end
    end
    // A clipping sample enters S2 on the same edge clip_clr is high: clear wins.
    in_vld = 1'b1; in_smpl = 16'sd32767;
    step();
    in_vld = 1'b0; clip_clr = 1'b1;
    step();
    clip_clr = 1'b0;
    drain();
    step();
    n_checks++;
    if (obs_clip !== 8'd0) $display("FAIL clip_clr_priority: got %0d expected 0", obs_clip);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc0;
    logic signed [DW-1:0] held;
    bit stable;
    clear_q();
    scale = 3'd4; out_rdy = 1'b0; in_vld = 1'b1;
    acc0 = n_acc;
    stable = 1'b1;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      in_smpl = DW'($urandom);
      step();
      if (i == 2) held = obs_out;
      if (i > 2 && obs_out !== held) stable = 1'b0;
    end
    n_checks++;
    if (n_acc - acc0 !== 2) $display("FAIL bp_accepted: got %0d expected 2", n_acc - acc0);
    else n_pass++;
    n_checks++;
    if (obs_in_rdy !== 1'b0 || obs_out_vld !== 1'b1)
      $display("FAIL bp_stall: got in_rdy=%b out_vld=%b expected in_rdy=0 out_vld=1", obs_in_rdy, obs_out_vld);
    else n_pass++;
    n_checks++;
    if (!stable || int'(held) !== exp_q[0]) $display("FAIL bp_hold: got %0d expected %0d", held, exp_q[0]);
    else n_pass++;
    out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_smpl = DW'($urandom);
      step();
    end
    drain();
    n_checks++;
    if (got_q.size() !== exp_q.size() || got_q.size() !== 8)
      $display("FAIL bp_count: got %0d expected 8", got_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_at(i) !== exp_q[i]) $display("FAIL bp_order[%0d]: got %0d expected %0d", i, got_at(i), exp_q[i]);
      else n_pass++;
    end
  endtask

`ifdef VOL_SCALER_RAMP_EN
  task automatic test_ramp();
    int want;
    rst = 1'b1; in_vld = 1'b0;
    step();
    rst = 1'b0; scale = 3'd7; out_rdy = 1'b1;
    clear_q();
    step();
    n_checks++;
    if (obs_busy !== 1'b1) $display("FAIL ramp_busy_start: got %b expected 1", obs_busy);
    else n_pass++;
    in_smpl = 16'sd4; in_vld = 1'b1;
    for (int i = 0; i < 64; i++) step();
    in_vld = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (obs_busy !== 1'b1) $display("FAIL ramp_busy_mid: got %b expected 1", obs_busy);
    else n_pass++;
    in_vld = 1'b1;
    for (int i = 0; i < 64; i++) step();
    in_vld = 1'b0;
    step();
    n_checks++;
    if (obs_busy !== 1'b0) $display("FAIL ramp_busy_done: got %b expected 0", obs_busy);
    else n_pass++;
    in_vld = 1'b1;
    step();
    drain();
    for (int i = 0; i < 129; i++) begin
      want = (i < 64) ? 5 : (i < 128) ? 6 : 7;
      n_checks++;
      if (got_at(i) !== want || exp_q[i] !== want)
        $display("FAIL ramp_gain[%0d]: got %0d expected %0d", i, got_at(i), want);
      else n_pass++;
    end
  endtask
`else
  task automatic test_gain_default();
    clear_q();
    busy_seen = 1'b0;
    scale = 3'd0; out_rdy = 1'b1; in_vld = 1'b1;
    in_smpl = 16'sd12345;
    step();
    in_smpl = -16'sd7;
    step();
    drain();
    n_checks++;
    if (got_at(0) !== 0 || got_at(1) !== 0)
      $display("FAIL zero_gain: got %0d,%0d expected 0,0", got_at(0), got_at(1));
    else n_pass++;
    scale = 3'd6;
    in_vld = 1'b1; in_smpl = 16'sd100;
    step();
    drain();
    n_checks++;
    if (got_at(2) !== 150) $display("FAIL gain_follow: got %0d expected 150", got_at(2));
    else n_pass++;
    n_checks++;
    if (busy_seen !== 1'b0) $display("FAIL ramp_busy_const: got %b expected 0", busy_seen);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_midflight();
    int want;
    clear_q();
    scale = 3'd7; out_rdy = 1'b0; in_vld = 1'b1; clip_clr = 1'b0;
    in_smpl = 16'sd32767;
    step();
    in_smpl = -16'sd32768;
    step();
    in_vld = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (obs_out_vld !== 1'b0) $display("FAIL mid_reset_out_vld: got %b expected 0", obs_out_vld);
    else n_pass++;
    n_checks++;
    if (obs_clip !== 8'd0) $display("FAIL mid_reset_clip: got %0d expected 0", obs_clip);
    else n_pass++;
    out_rdy = 1'b1; in_vld = 1'b1; in_smpl = 16'sd4;
    step();
    drain();
`ifdef VOL_SCALER_RAMP_EN
    want = 5;
`else
    want = 7;
`endif
    n_checks++;
    if (got_q.size() !== 1 || got_at(0) !== want)
      $display("FAIL mid_reset_gain: got n=%0d out=%0d expected n=1 out=%0d", got_q.size(), got_at(0), want);
    else n_pass++;
  endtask

  task automatic test_random();
    clip_clr = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
    step();
    clip_clr = 1'b0;
    clear_q();
    for (int i = 0; i < 600; i++) begin
      in_vld  = ($urandom_range(3, 0) != 0);
      out_rdy = ($urandom_range(3, 0) != 0);
      case ($urandom_range(7, 0))
        0:       in_smpl = 16'sh7FFF;
        1:       in_smpl = 16'sh8000;
        default: in_smpl = DW'($urandom);
      endcase
      if ($urandom_range(39, 0) == 0) scale = 3'($urandom);
      step();
    end
    out_rdy = 1'b1;
    drain();
    step();
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_at(i) !== exp_q[i]) $display("FAIL rand_out[%0d]: got %0d expected %0d", i, got_at(i), exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (int'(obs_clip) !== m_clip) $display("FAIL rand_clip_cnt: got %0d expected %0d", obs_clip, m_clip);
    else n_pass++;
  endtask

  initial begin
    busy_seen = 1'b0;
    test_reset();
    test_basic();
    test_clip();
    test_backpressure();
`ifdef VOL_SCALER_RAMP_EN
    test_ramp();
`else
    test_gain_default();
`endif
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
